rv32i_decode_exec: RTL and testbench
====================================

// Module: rv32i_decode_exec
// PURPOSE
//  Registered RV32I decode/execute slice of the multi-cycle core: main control decoder,
//  immediate extender and integer ALU merged into one clocked block.
//  Takes the fetched instruction and the two register-file operand values.
//  Returns control selects, the extended immediate and the ALU result, one cycle later.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported.
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     reset; synchronous, active-high
//  in_valid     in   1     instr/rs1/rs2 valid this cycle
//  instr        in   32    instruction word
//  rs1          in   32    rs1 register value
//  rs2          in   32    rs2 register value
//  out_valid    out  1     registered outputs are valid (in_valid delayed 1 cycle)
//  alu_result   out  32    ALU result
//  imm_ext      out  32    sign-extended immediate
//  alu_control  out  4     ALU opcode used
//  alu_src      out  1     1 = ALU in2 is imm_ext; 0 = ALU in2 is rs2
//  result_src   out  3     writeback select: 0 ALU, 1 imm, 2 pc+imm, 3 pc+4, 4 mem
//  pc_src       out  2     0 pc+4; 1 pc+imm; 2 (rs1+imm)&~1; 3 branch: pc+imm if alu_result[0], else pc+4
//  instr_type   out  3     0 R, 1 I, 2 S, 3 B, 4 U, 5 J
//  illegal      out  1     unknown opcode/funct (ILLEGAL_DETECT_EN only)
// BEHAVIOUR
//  - Latency and capture:
//    - Combinational decode of instr/rs1/rs2; all outputs registered on the clk edge.
//    - Latency is exactly 1 cycle.
//    - Outputs update only when in_valid=1; otherwise they hold.
//    - out_valid <= in_valid every cycle.
//  - Reset (rst=1 at the edge): all outputs 0, out_valid=0; wins over a simultaneous in_valid.
//  - Opcodes, per opcode (pc_src / result_src / alu_src / type / ALU op):
//    - OP 0110011: pc 0, res 0, src 0, R; ALU op per funct3/funct7[5] (instr[30]):
//      ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
//    - OP_IMM 0010011: pc 0, res 0, src 1, I; same mapping.
//      instr[30] is honoured only for funct3=101 (SRAI); funct3=000 is always ADD.
//    - LOAD 0000011: pc 0, res 4, src 1, I; ADD.
//    - STORE 0100011: pc 0, res 0, src 1, S; ADD.
//    - BRANCH 1100011: pc 3, res 0, src 0, B.
//      funct3 000 EQ, 001 NE, 100 SLT, 101 GE, 110 SLTU, 111 GEU.
//    - JAL 1101111: pc 1, res 3, J; ADD.
//    - JALR 1100111: pc 2, res 3, src 1, I; ADD.
//    - LUI 0110111: pc 0, res 1, U; ADD.
//    - AUIPC 0010111: pc 0, res 2, U; ADD.
//    - Any other opcode: all selects 0, type R, ADD.
//  - ALU codes and functions:
//    - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
//    - 10 EQ, 11 NE, 12 GE (signed), 13 GEU; 14-15 give 0.
//    - Compare ops return 32'h1 or 32'h0.
//    - Shifts use in2[4:0]; SRA is arithmetic.
//    - ADD/SUB wrap modulo 2^32, with no flags.
//  - Immediates (sign bit instr[31]):
//    - I: instr[31:20]
//    - S: {instr[31:25],instr[11:7]}
//    - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//    - U: {instr[31:12],12'b0}
//    - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//    - R type gives imm 0.
// CONFIGURATION
//  - ILLEGAL_DETECT_EN defined: port illegal exists.
//    - Set to 1 for an unknown opcode.
//    - Set to 1 for an OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}.
//    - Set to 1 for a BRANCH with funct3 010/011.
//    - Set to 1 for an OP_IMM shift with an illegal funct7.
//    - Registered with the other outputs; reset value 0.
//  - ILLEGAL_DETECT_EN not defined: no illegal port; decode is otherwise identical.
// TESTING
//  - Reset: rst=1 for 2 cycles with in_valid=1 -> all outputs 0, out_valid=0.
//  - ADD R-type:
//    - Stimulus: instr=32'h002081B3 (add x3,x1,x2), rs1=5, rs2=7.
//    - Next cycle: alu_result=12, alu_src=0, result_src=0, instr_type=0.
//  - SRAI:
//    - Stimulus: instr=32'h4040D093 (srai x1,x1,4), rs1=32'h80000000.
//    - Response: alu_result=32'hF8000000, imm_ext[4:0]=4, alu_src=1.
//  - BEQ taken:
//    - Stimulus: instr=32'hFE208EE3 (beq x1,x2,-4), rs1=rs2=9.
//    - Response: imm_ext=32'hFFFFFFFC, alu_result=1, pc_src=3, instr_type=3.
//  - JAL: instr=32'h0080006F -> imm_ext=8, pc_src=1, result_src=3, instr_type=5.
//  - LUI / hold:
//    - Stimulus: instr=32'hABCDE0B7 (lui), then in_valid=0 for 3 cycles.
//    - Response: imm_ext=32'hABCDE000, result_src=1; outputs hold; out_valid=0.

Source files
------------

// File: rtl/rv32i_decode_exec_if.sv
// Decode/execute slice bundle: instruction + operands in, registered
// control, immediate and ALU result out. illegal exists with ILLEGAL_DETECT_EN.
interface rv32i_decode_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] imm_ext;
  logic [3:0]      alu_control;
  logic            alu_src;
  logic [2:0]      result_src;
  logic [1:0]      pc_src;
  logic [2:0]      instr_type;
`ifdef ILLEGAL_DETECT_EN
  logic            illegal;
`endif

  modport master (
`ifdef ILLEGAL_DETECT_EN
    input  illegal,
`endif
    output in_valid, instr, rs1, rs2,
    input  out_valid, alu_result, imm_ext,
    input  alu_control, alu_src, result_src,
    input  pc_src, instr_type
  );

  modport slave (
`ifdef ILLEGAL_DETECT_EN
    output illegal,
`endif
    input  in_valid, instr, rs1, rs2,
    output out_valid, alu_result, imm_ext,
    output alu_control, alu_src, result_src,
    output pc_src, instr_type
  );
endinterface

// File: rtl/rv32i_decode_exec.sv
// RV32I registered decode/execute: control decoder, imm extender, ALU.
// Ports: clk, rst (sync, active-high), bus (slave). Macro: ILLEGAL_DETECT_EN.
module rv32i_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  rv32i_decode_exec_if.slave bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

  // funct3 -> ALU code; alt selects SUB / SRA
  function automatic logic [3:0] f_arith(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [3:0] f_branch(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'd10;
      3'b001:  return 4'd11;
      3'b100:  return 4'd3;
      3'b101:  return 4'd12;
      3'b110:  return 4'd4;
      3'b111:  return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  logic [31:0]     w_in;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_f7_ok;
  logic [3:0]      w_ctl;
  logic            w_src;
  logic [2:0]      w_res;
  logic [1:0]      w_pc;
  logic [2:0]      w_type;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_in2;
  logic [XLEN-1:0] w_alu;
  logic [4:0]      w_sh;

  assign w_in    = bus.instr;
  assign w_op    = w_in[6:0];
  assign w_f3    = w_in[14:12];
  assign w_f7    = w_in[31:25];
  assign w_f7_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);

  always_comb begin
    w_ctl  = 4'd0;
    w_src  = 1'b0;
    w_res  = 3'd0;
    w_pc   = 2'd0;
    w_type = T_R;
    w_ill  = 1'b0;
    unique case (1'b1)
      (w_op == OP_R): begin
        w_ctl = f_arith(w_f3, w_in[30]);
        w_ill = !w_f7_ok || ((w_f7 == 7'h20) &&
                (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      (w_op == OP_I): begin
        w_ctl  = f_arith(w_f3, (w_f3 == 3'b101) && w_in[30]);
        w_src  = 1'b1;
        w_type = T_I;
        w_ill  = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                 ((w_f3 == 3'b101) && !w_f7_ok);
      end
      (w_op == OP_LD): begin
        w_res  = 3'd4;
        w_src  = 1'b1;
        w_type = T_I;
      end
      (w_op == OP_ST): begin
        w_src  = 1'b1;
        w_type = T_S;
      end
      (w_op == OP_BR): begin
        w_ctl  = f_branch(w_f3);
        w_pc   = 2'd3;
        w_type = T_B;
        w_ill  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      (w_op == OP_JAL): begin
        w_pc   = 2'd1;
        w_res  = 3'd3;
        w_type = T_J;
      end
      (w_op == OP_JR): begin
        w_pc   = 2'd2;
        w_res  = 3'd3;
        w_src  = 1'b1;
        w_type = T_I;
      end
      (w_op == OP_LUI): begin
        w_res  = 3'd1;
        w_type = T_U;
      end
      (w_op == OP_AUI): begin
        w_res  = 3'd2;
        w_type = T_U;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (w_type)
      T_I: w_imm = {{20{w_in[31]}}, w_in[31:20]};
      T_S: w_imm = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]};
      T_B: w_imm = {{20{w_in[31]}}, w_in[7], w_in[30:25],
                    w_in[11:8], 1'b0};
      T_U: w_imm = {w_in[31:12], 12'b0};
      T_J: w_imm = {{12{w_in[31]}}, w_in[19:12], w_in[20],
                    w_in[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign w_in2 = w_src ? w_imm : bus.rs2;
  assign w_sh  = w_in2[4:0];

  always_comb begin
    case (w_ctl)
      4'd0:  w_alu = bus.rs1 + w_in2;
      4'd1:  w_alu = bus.rs1 - w_in2;
      4'd2:  w_alu = bus.rs1 << w_sh;
      4'd3:  w_alu = {31'd0, $signed(bus.rs1) < $signed(w_in2)};
      4'd4:  w_alu = {31'd0, bus.rs1 < w_in2};
      4'd5:  w_alu = bus.rs1 ^ w_in2;
      4'd6:  w_alu = bus.rs1 >> w_sh;
      4'd7:  w_alu = $unsigned($signed(bus.rs1) >>> w_sh);
      4'd8:  w_alu = bus.rs1 | w_in2;
      4'd9:  w_alu = bus.rs1 & w_in2;
      4'd10: w_alu = {31'd0, bus.rs1 == w_in2};
      4'd11: w_alu = {31'd0, bus.rs1 != w_in2};
      4'd12: w_alu = {31'd0, $signed(bus.rs1) >= $signed(w_in2)};
      4'd13: w_alu = {31'd0, bus.rs1 >= w_in2};
      default: w_alu = '0;
    endcase
  end

  logic            r_vld;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_ctl;
  logic            r_src;
  logic [2:0]      r_res;
  logic [1:0]      r_pc;
  logic [2:0]      r_type;
  logic            r_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_alu  <= '0;
      r_imm  <= '0;
      r_ctl  <= 4'd0;
      r_src  <= 1'b0;
      r_res  <= 3'd0;
      r_pc   <= 2'd0;
      r_type <= 3'd0;
      r_ill  <= 1'b0;
    end else begin
      r_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_alu  <= w_alu;
        r_imm  <= w_imm;
        r_ctl  <= w_ctl;
        r_src  <= w_src;
        r_res  <= w_res;
        r_pc   <= w_pc;
        r_type <= w_type;
        r_ill  <= w_ill;
      end
    end
  end

  assign bus.out_valid   = r_vld;
  assign bus.alu_result  = r_alu;
  assign bus.imm_ext     = r_imm;
  assign bus.alu_control = r_ctl;
  assign bus.alu_src     = r_src;
  assign bus.result_src  = r_res;
  assign bus.pc_src      = r_pc;
  assign bus.instr_type  = r_type;
`ifdef ILLEGAL_DETECT_EN
  assign bus.illegal     = r_ill;
`else
  logic w_unused;
  assign w_unused = r_ill;
`endif
endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Bench for rv32i_decode_exec: directed vector table, hand sequences,
// random stimulus against an instruction-level reference model.
module tb_rv32i_decode_exec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_decode_exec_if bus();
  rv32i_decode_exec dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] imm;
    logic [3:0]  ctl;
    logic        src;
    logic [2:0]  res;
    logic [1:0]  pc;
    logic [2:0]  typ;
    logic        ill;
    logic        vld;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(
    logic [31:0] i, logic [31:0] a, logic [31:0] b,
    logic [31:0] alu, logic [31:0] imm, logic [3:0] ctl,
    logic src, logic [2:0] res, logic [1:0] pc,
    logic [2:0] typ, logic ill);
    vec_t v;
    v.instr = i; v.rs1 = a; v.rs2 = b;
    v.e.alu = alu; v.e.imm = imm; v.e.ctl = ctl;
    v.e.src = src; v.e.res = res; v.e.pc = pc;
    v.e.typ = typ; v.e.ill = ill; v.e.vld = 1'b1;
    return v;
  endfunction

  // Value of an ALU operation, straight from its definition
  function automatic logic [31:0] eval(
    logic [3:0] c, logic [31:0] a, logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    int sh = int'(b % 32);
    case (c)
      0: return a + b;
      1: return a - b;
      2: return a * (32'd1 << sh);
      3: return (sa < sb) ? 1 : 0;
      4: return (a < b) ? 1 : 0;
      5: return a ^ b;
      6: return a / (33'd1 << sh);
      7: return sa >>> sh;
      8: return a | b;
      9: return a & b;
      10: return (a == b) ? 1 : 0;
      11: return (a != b) ? 1 : 0;
      12: return (sa >= sb) ? 1 : 0;
      13: return (a >= b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(
    logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [3:0] arith [8];
    logic [3:0] brc [8];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit f7ok = (f7 == 0) || (f7 == 7'h20);
    arith = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    brc   = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd3, 4'd12, 4'd4, 4'd13};
    e = '0;
    e.vld = 1'b1;
    case (ins[6:0])
      7'h33: begin
        e.ctl = arith[f3];
        if (ins[30] && f3 == 0) e.ctl = 1;
        if (ins[30] && f3 == 5) e.ctl = 7;
        e.ill = !f7ok || (f7 == 7'h20 && f3 != 0 && f3 != 5);
      end
      7'h13: begin
        e.typ = 1; e.src = 1;
        e.ctl = arith[f3];
        if (ins[30] && f3 == 5) e.ctl = 7;
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !f7ok);
      end
      7'h03: begin e.typ = 1; e.src = 1; e.res = 4; end
      7'h23: begin e.typ = 2; e.src = 1; end
      7'h63: begin
        e.typ = 3; e.pc = 3; e.ctl = brc[f3];
        e.ill = (f3 == 2) || (f3 == 3);
      end
      7'h6F: begin e.typ = 5; e.pc = 1; e.res = 3; end
      7'h67: begin e.typ = 1; e.pc = 2; e.res = 3; e.src = 1; end
      7'h37: begin e.typ = 4; e.res = 1; end
      7'h17: begin e.typ = 4; e.res = 2; end
      default: e.ill = 1'b1;
    endcase
    case (e.typ)
      1: e.imm = 32'($signed(ins[31:20]));
      2: e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      3: e.imm = 32'($signed({ins[31], ins[7], ins[30:25],
                               ins[11:8], 1'b0}));
      4: e.imm = {ins[31:12], 12'h000};
      5: e.imm = 32'($signed({ins[31], ins[19:12], ins[20],
                               ins[30:21], 1'b0}));
      default: e.imm = 0;
    endcase
    e.alu = eval(e.ctl, a, e.src ? e.imm : b);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic check_out(string tag, exp_t e);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(e.vld));
    chk({tag, " alu_result"}, bus.alu_result, e.alu);
    chk({tag, " imm_ext"}, bus.imm_ext, e.imm);
    chk({tag, " alu_control"}, 32'(bus.alu_control), 32'(e.ctl));
    chk({tag, " alu_src"}, 32'(bus.alu_src), 32'(e.src));
    chk({tag, " result_src"}, 32'(bus.result_src), 32'(e.res));
    chk({tag, " pc_src"}, 32'(bus.pc_src), 32'(e.pc));
    chk({tag, " instr_type"}, 32'(bus.instr_type), 32'(e.typ));
`ifdef ILLEGAL_DETECT_EN
    chk({tag, " illegal"}, 32'(bus.illegal), 32'(e.ill));
`endif
  endtask

  task automatic drive(logic v, logic [31:0] i,
                       logic [31:0] a, logic [31:0] b);
    bus.in_valid = v; bus.instr = i;
    bus.rs1 = a; bus.rs2 = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];
  exp_t cur;
  exp_t lui_e;

  initial begin
    tbl[0]  = mk(32'h002081B3, 5, 7, 12, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h4040D093, 32'h80000000, 0,
                 32'hF8000000, 32'h404, 7, 1, 0, 0, 1, 0);
    tbl[2]  = mk(32'hFE208EE3, 9, 9, 1, 32'hFFFFFFFC,
                 10, 0, 0, 3, 3, 0);
    tbl[3]  = mk(32'h0080006F, 0, 0, 0, 8, 0, 0, 3, 1, 5, 0);
    tbl[4]  = mk(32'hABCDE0B7, 0, 0, 0, 32'hABCDE000,
                 0, 0, 1, 0, 4, 0);
    tbl[5]  = mk(32'h40208133, 3, 5, 32'hFFFFFFFE, 0,
                 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(32'h0020B1B3, 1, 32'hFFFFFFFF, 1, 0,
                 4, 0, 0, 0, 0, 0);
    tbl[7]  = mk(32'h0020A223, 100, 0, 104, 4, 0, 1, 0, 0, 2, 0);
    tbl[8]  = mk(32'h0000007F, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(32'h0020D463, 32'hFFFFFFFF, 1, 0, 8,
                 12, 0, 0, 3, 3, 0);
    tbl[10] = mk(32'h00C08067, 32'h1001, 0, 32'h100D, 12,
                 0, 1, 3, 2, 1, 0);
    tbl[11] = mk(32'h00001097, 2, 3, 5, 32'h1000, 0, 0, 2, 0, 4, 0);
    tbl[12] = mk(32'h0220A1B3, 32'hFFFFFFFB, 2, 1, 0,
                 3, 0, 0, 0, 0, 1);

    // reset held with a valid instruction present
    rst = 1'b1;
    drive(1'b1, 32'h002081B3, 5, 7);
    step();
    step();
    check_out("reset", '0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(1'b1, tbl[k].instr, tbl[k].rs1, tbl[k].rs2);
      step();
      check_out($sformatf("vec%0d", k), tbl[k].e);
    end

    // LUI then three idle cycles: outputs hold, out_valid low
    lui_e = tbl[4].e;
    drive(1'b1, 32'hABCDE0B7, 0, 0);
    step();
    check_out("lui", lui_e);
    lui_e.vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h002081B3, 32'h11, 32'h22);
      step();
      check_out($sformatf("hold%0d", c), lui_e);
    end

    // reset beats a simultaneous valid
    rst = 1'b1;
    drive(1'b1, 32'hFE208EE3, 9, 9);
    step();
    check_out("rst_wins", '0);
    rst = 1'b0;

    cur = '0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [10];
      logic [31:0] ins, a, b;
      logic v, r;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
              7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(9)];
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom());
      if ($urandom_range(3) != 0)
        ins[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
      a = $urandom();
      b = ($urandom_range(3) == 0) ? a : $urandom();
      v = ($urandom_range(4) != 0);
      r = ($urandom_range(29) == 0);
      rst = r;
      drive(v, ins, a, b);
      step();
      if (r) cur = '0;
      else if (v) cur = model(ins, a, b);
      else cur.vld = 1'b0;
      check_out($sformatf("rnd%0d", n), cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
